// File: rtl/dmem_pkg.sv
// Shared types and defaults for the wait-state data memory responder.
package dmem_pkg;

    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_DEPTH       = 200;
    localparam int DEF_WAIT_CYCLES = 2;

    // Wide enough for the largest legal wait-state count (15).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage: synchronous write, combinational read, contents never reset.
module dmem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 200
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;

    // The caller only writes or uses read data when addr < DEPTH.
    assign idx   = addr[IDX_W-1:0];
    assign rdata = mem[idx];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with a fixed number of access wait states.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // req_ready is high only in IDLE; rsp_valid is high only in RESP, and the
    // response payload stays frozen until the edge that sees rsp_ready.

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic              cap_write;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic              accept;
    logic              access;
    logic              in_range;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign state_dbg = state;
    assign in_range  = ({1'b0, cap_addr} < DEPTH_L);
    assign mem_we    = access && cap_write && in_range;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    access     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_W'(WAIT_CYCLES);
        end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Request fields are sampled only at acceptance, so later req_* wiggles are inert.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (accept) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (access) begin
            rsp_rdata <= (!cap_write && in_range) ? mem_rdata : '0;
            rsp_err   <= !in_range;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (cap_addr),
        .wdata (cap_wdata),
        .rdata (mem_rdata)
    );

endmodule
